lcd_bus_arbiter: RTL and testbench

//  Shares the 4-bit HD44780 LCD bus (lcd_flags/lcd_data) between two byte-level requesters.

---
 rtl/lcd_bus_arbiter_pkg.sv | 25 ++
 rtl/lcd_bus_arbiter_if.sv | 31 +++
 rtl/lcd_bus_arbiter_rr_arb2.sv | 28 ++
 rtl/lcd_bus_arbiter.sv | 141 ++++++++++++++
 tb/tb_lcd_bus_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_bus_arbiter_pkg.sv
// Shared definitions for the LCD bus arbiter: FSM state encoding and HD44780 bus codes.
package lcd_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_UP_SETUP  = 3'd1,
    ST_UP_PULSE  = 3'd2,
    ST_GAP       = 3'd3,
    ST_LO_SETUP  = 3'd4,
    ST_LO_PULSE  = 3'd5,
    ST_EXEC_WAIT = 3'd6
  } lcd_state_t;

  localparam logic [1:0] LCD_FLAG_CMD_E  = 2'b01;
  localparam logic [1:0] LCD_FLAG_DATA_E = 2'b11;

  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

  // Clear (0x01) and return-home (0x02/0x03, bit 0 is don't-care) need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] cmd);
    return !rs && ((cmd == LCD_CMD_CLEAR) || (cmd[7:1] == LCD_CMD_HOME[7:1]));
  endfunction

endpackage

// File: rtl/lcd_bus_arbiter_if.sv
// Requester handshakes plus the 4-bit LCD bus; slave = arbiter, master = requesters/panel side.
interface lcd_bus_arbiter_if;
  logic       bus_en;
  logic       req0_valid;
  logic       req0_rs;
  logic [7:0] req0_byte;
  logic       req0_ready;
  logic       req1_valid;
  logic       req1_rs;
  logic [7:0] req1_byte;
  logic       req1_ready;
  logic       busy;
  logic [1:0] lcd_flags;
  logic [3:0] lcd_data;

  modport slave (
    input  bus_en,
    input  req0_valid, req0_rs, req0_byte,
    input  req1_valid, req1_rs, req1_byte,
    output req0_ready, req1_ready,
    output busy, lcd_flags, lcd_data
  );

  modport master (
    output bus_en,
    output req0_valid, req0_rs, req0_byte,
    output req1_valid, req1_rs, req1_byte,
    input  req0_ready, req1_ready,
    input  busy, lcd_flags, lcd_data
  );
endinterface

// File: rtl/lcd_bus_arbiter_rr_arb2.sv
// Two-way round-robin grant; a tie goes to whichever requester was not granted last.
module lcd_rr_arb2 (
  input  logic       qzt_clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic last;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge qzt_clk) begin
    if (rst)         last <= 1'b1;
    else if (gnt[1]) last <= 1'b1;
    else if (gnt[0]) last <= 1'b0;
  end
endmodule

// File: rtl/lcd_bus_arbiter.sv
// Shares the 4-bit HD44780 bus between two byte requesters; each byte goes out as two strobed
// nibbles followed by the command execution hold-off.
//   state      | meaning
//   IDLE       | arbitrate, latch the winning byte, place upper nibble
//   UP_SETUP   | upper nibble settling before E
//   UP_PULSE   | E high for upper nibble
//   GAP        | E low between nibbles
//   LO_SETUP   | lower nibble settling before E
//   LO_PULSE   | E high for lower nibble
//   EXEC_WAIT  | panel executing (long for clear/home)
module lcd_bus_arbiter
  import lcd_bus_arbiter_pkg::*;
#(
  parameter int T_SETUP = 16,
  parameter int T_PULSE = 16,
  parameter int T_GAP   = 64,
  parameter int T_EXEC  = 2048,
  parameter int T_LONG  = 98304,
  parameter int CW      = 17
) (
  input logic              qzt_clk,
  input logic              rst,
  lcd_bus_arbiter_if.slave bus
);
  localparam logic [CW-1:0] SETUP_LAST = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(T_PULSE - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(T_GAP - 1);
  localparam logic [CW-1:0] EXEC_LAST  = CW'(T_EXEC - 1);
  localparam logic [CW-1:0] LONG_LAST  = CW'(T_LONG - 1);

  lcd_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n, wait_last;
  logic          rs_q, rs_n;
  logic [7:0]    byte_q, byte_n;
  logic [1:0]    flags_q, flags_n;
  logic [3:0]    data_q, data_n;
  logic [1:0]    ready_q, ready_n;
  logic          busy_q;
  logic [1:0]    gnt;
  logic          arb_en;

  assign arb_en = (state == ST_IDLE) && bus.bus_en;

  lcd_rr_arb2 u_arb (
    .qzt_clk (qzt_clk),
    .rst     (rst),
    .en      (arb_en),
    .req     ({bus.req1_valid, bus.req0_valid}),
    .gnt     (gnt)
  );

  assign wait_last = is_long_cmd(rs_q, byte_q) ? LONG_LAST : EXEC_LAST;

  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    rs_n    = rs_q;
    byte_n  = byte_q;
    flags_n = flags_q;
    data_n  = data_q;
    ready_n = 2'b00;
    case (state)
      ST_IDLE: begin
        cnt_n   = '0;
        flags_n = 2'b00;
        data_n  = 4'h0;
        if (gnt != 2'b00) begin
          rs_n    = gnt[1] ? bus.req1_rs   : bus.req0_rs;
          byte_n  = gnt[1] ? bus.req1_byte : bus.req0_byte;
          ready_n = gnt;
          flags_n = {rs_n, 1'b0};
          data_n  = byte_n[7:4];
          state_n = ST_UP_SETUP;
        end
      end
      ST_UP_SETUP: if (cnt == SETUP_LAST) begin
        flags_n = rs_q ? LCD_FLAG_DATA_E : LCD_FLAG_CMD_E;
        state_n = ST_UP_PULSE;
        cnt_n   = '0;
      end
      ST_UP_PULSE: if (cnt == PULSE_LAST) begin
        flags_n = {rs_q, 1'b0};
        state_n = ST_GAP;
        cnt_n   = '0;
      end
      ST_GAP: if (cnt == GAP_LAST) begin
        data_n  = byte_q[3:0];
        state_n = ST_LO_SETUP;
        cnt_n   = '0;
      end
      ST_LO_SETUP: if (cnt == SETUP_LAST) begin
        flags_n = rs_q ? LCD_FLAG_DATA_E : LCD_FLAG_CMD_E;
        state_n = ST_LO_PULSE;
        cnt_n   = '0;
      end
      ST_LO_PULSE: if (cnt == PULSE_LAST) begin
        flags_n = {rs_q, 1'b0};
        data_n  = 4'h0;
        state_n = ST_EXEC_WAIT;
        cnt_n   = '0;
      end
      ST_EXEC_WAIT: if (cnt == wait_last) begin
        flags_n = 2'b00;
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge qzt_clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      rs_q    <= 1'b0;
      byte_q  <= 8'h00;
      flags_q <= 2'b00;
      data_q  <= 4'h0;
      ready_q <= 2'b00;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      rs_q    <= rs_n;
      byte_q  <= byte_n;
      flags_q <= flags_n;
      data_q  <= data_n;
      ready_q <= ready_n;
      busy_q  <= (state_n != ST_IDLE);
    end
  end

  assign bus.req0_ready = ready_q[0];
  assign bus.req1_ready = ready_q[1];
  assign bus.busy       = busy_q;
  assign bus.lcd_flags  = flags_q;
  assign bus.lcd_data   = data_q;
endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Directed bench for lcd_bus_arbiter with shortened timing; a negedge monitor decodes strobed
// nibble pairs against the bytes each ready pulse accepted.
module tb_lcd_bus_arbiter;
  localparam int TS = 4;
  localparam int TP = 3;
  localparam int TG = 6;
  localparam int TE = 20;
  localparam int TL = 150;
  localparam int PER      = 1 + 2 * (TS + TP) + TG + TE;
  localparam int PER_LONG = 1 + 2 * (TS + TP) + TG + TL;

  logic qzt_clk = 1'b0;
  logic rst     = 1'b1;
  always #5 qzt_clk = ~qzt_clk;

  lcd_bus_arbiter_if bus_if ();

  lcd_bus_arbiter #(
    .T_SETUP (TS),
    .T_PULSE (TP),
    .T_GAP   (TG),
    .T_EXEC  (TE),
    .T_LONG  (TL),
    .CW      (17)
  ) dut (
    .qzt_clk (qzt_clk),
    .rst     (rst),
    .bus     (bus_if)
  );

  int         n_vec  = 0;
  int         n_miss = 0;
  logic [8:0] exp_q[$];
  int         n_acc  = 0;
  int         n_dec  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge qzt_clk);
    #1;
  endtask

  task automatic wait_ready(input int bound, output int who, output int cyc);
    who = -1;
    cyc = 0;
    while (who < 0 && cyc < bound) begin
      tick(1);
      cyc++;
      if (bus_if.req0_ready) who = 0;
      else if (bus_if.req1_ready) who = 1;
    end
    if (who < 0) check_val("ready_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int bound);
    int cyc;
    cyc = 0;
    while (bus_if.busy && cyc < bound) begin
      tick(1);
      cyc++;
    end
    if (bus_if.busy) check_val("idle_timeout", 1, 0);
  endtask

  // Monitor: inputs are saved each negedge so a ready pulse can be matched to what was latched.
  logic       e_prev = 1'b0;
  logic       half   = 1'b0;
  int         e_len  = 0;
  logic [3:0] hi_nib;
  logic       hi_rs;
  logic [8:0] s0 = '0;
  logic [8:0] s1 = '0;
  logic [8:0] obs;
  int         exp_v;

  always @(negedge qzt_clk) begin
    if (bus_if.req0_ready || bus_if.req1_ready)
      check_val("ready_excl", 32'(bus_if.req0_ready & bus_if.req1_ready), 0);
    if (bus_if.req0_ready) begin exp_q.push_back(s0); n_acc++; end
    if (bus_if.req1_ready) begin exp_q.push_back(s1); n_acc++; end
    s0 = {bus_if.req0_rs, bus_if.req0_byte};
    s1 = {bus_if.req1_rs, bus_if.req1_byte};
    if (rst) begin
      e_prev = 1'b0;
      half   = 1'b0;
      e_len  = 0;
    end else begin
      if (bus_if.lcd_flags[0]) begin
        e_len++;
        if (!e_prev) begin
          if (!half) begin
            hi_nib = bus_if.lcd_data;
            hi_rs  = bus_if.lcd_flags[1];
            half   = 1'b1;
          end else begin
            half  = 1'b0;
            n_dec++;
            obs   = {hi_rs, hi_nib, bus_if.lcd_data};
            exp_v = (exp_q.size() > 0) ? int'(exp_q.pop_front()) : 'hDEAD;
            check_val("sb_byte", 32'(obs), exp_v);
          end
        end
      end else if (e_prev) begin
        check_val("e_width", 32'(e_len), TP);
        e_len = 0;
      end
      e_prev = bus_if.lcd_flags[0];
    end
  end

  logic [8:0] bnd_cmd[5] = '{9'h002, 9'h003, 9'h004, 9'h000, 9'h101};
  int         bnd_per[5] = '{PER_LONG, PER_LONG, PER, PER, PER};

  initial begin
    int   who, cyc;
    logic saw;

    bus_if.bus_en     = 1'b0;
    bus_if.req0_valid = 1'b0;
    bus_if.req0_rs    = 1'b0;
    bus_if.req0_byte  = 8'h00;
    bus_if.req1_valid = 1'b0;
    bus_if.req1_rs    = 1'b0;
    bus_if.req1_byte  = 8'h00;
    rst = 1'b1;
    tick(3);
    check_val("rst_flags", 32'(bus_if.lcd_flags), 0);
    check_val("rst_data", 32'(bus_if.lcd_data), 0);
    check_val("rst_busy", 32'(bus_if.busy), 0);
    check_val("rst_ready", 32'({bus_if.req1_ready, bus_if.req0_ready}), 0);
    rst = 1'b0;
    bus_if.bus_en = 1'b1;
    tick(1);

    // single data byte 0x41 from req0, walked through every phase
    bus_if.req0_valid = 1'b1;
    bus_if.req0_rs    = 1'b1;
    bus_if.req0_byte  = 8'h41;
    tick(1);
    check_val("a_ready", 32'({bus_if.req1_ready, bus_if.req0_ready}), 'b01);
    check_val("a_busy", 32'(bus_if.busy), 1);
    check_val("a_up_data", 32'(bus_if.lcd_data), 4);
    check_val("a_up_flags", 32'(bus_if.lcd_flags), 'b10);
    bus_if.req0_valid = 1'b0;
    tick(TS - 1);
    check_val("a_setup_flags", 32'(bus_if.lcd_flags), 'b10);
    tick(1);
    check_val("a_up_e", 32'(bus_if.lcd_flags), 'b11);
    check_val("a_up_e_data", 32'(bus_if.lcd_data), 4);
    tick(TP);
    check_val("a_gap_flags", 32'(bus_if.lcd_flags), 'b10);
    tick(TG);
    check_val("a_lo_data", 32'(bus_if.lcd_data), 1);
    tick(TS);
    check_val("a_lo_e", 32'(bus_if.lcd_flags), 'b11);
    tick(TP);
    check_val("a_exec_flags", 32'(bus_if.lcd_flags), 'b10);
    check_val("a_exec_data", 32'(bus_if.lcd_data), 0);
    tick(TE - 1);
    check_val("a_exec_busy", 32'(bus_if.busy), 1);
    tick(1);
    check_val("a_idle_busy", 32'(bus_if.busy), 0);
    check_val("a_idle_flags", 32'(bus_if.lcd_flags), 0);

    // both requesting right after reset: req0 first, then strict alternation
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    exp_q.delete();
    bus_if.req0_valid = 1'b1; bus_if.req0_rs = 1'b1; bus_if.req0_byte = 8'h30;
    bus_if.req1_valid = 1'b1; bus_if.req1_rs = 1'b1; bus_if.req1_byte = 8'h31;
    tick(1);
    check_val("b_first", 32'({bus_if.req1_ready, bus_if.req0_ready}), 'b01);
    bus_if.req0_valid = 1'b0;
    wait_ready(PER + 5, who, cyc);
    check_val("b_second_who", 32'(who), 1);
    check_val("b_period", 32'(cyc), PER);
    bus_if.req1_valid = 1'b0;
    bus_if.req0_valid = 1'b1; bus_if.req0_byte = 8'h32;
    bus_if.req1_valid = 1'b1; bus_if.req1_byte = 8'h33;
    wait_ready(PER + 5, who, cyc);
    check_val("b_third_who", 32'(who), 0);
    bus_if.req0_valid = 1'b0;
    wait_ready(PER + 5, who, cyc);
    check_val("b_fourth_who", 32'(who), 1);
    bus_if.req1_valid = 1'b0;
    wait_idle(PER + 5);

    // clear display from req1; req0 must wait out the long hold-off
    bus_if.req1_valid = 1'b1; bus_if.req1_rs = 1'b0; bus_if.req1_byte = 8'h01;
    tick(1);
    check_val("c_grant", 32'({bus_if.req1_ready, bus_if.req0_ready}), 'b10);
    bus_if.req1_valid = 1'b0;
    bus_if.req0_valid = 1'b1; bus_if.req0_rs = 1'b1; bus_if.req0_byte = 8'h55;
    wait_ready(PER_LONG + 5, who, cyc);
    check_val("c_who", 32'(who), 0);
    check_val("c_period", 32'(cyc), PER_LONG);
    bus_if.req0_valid = 1'b0;

    // long/short boundary of the execution wait
    for (int i = 0; i < 5; i++) begin
      wait_idle(PER_LONG + 5);
      bus_if.req0_valid = 1'b1;
      bus_if.req0_rs    = bnd_cmd[i][8];
      bus_if.req0_byte  = bnd_cmd[i][7:0];
      tick(1);
      check_val("bnd_grant", 32'(bus_if.req0_ready), 1);
      bus_if.req0_rs   = 1'b1;
      bus_if.req0_byte = 8'h20;
      wait_ready(PER_LONG + 5, who, cyc);
      check_val("bnd_period", 32'(cyc), bnd_per[i]);
      bus_if.req0_valid = 1'b0;
    end
    wait_idle(PER + 5);

    // bus_en gating, and bus_en dropping mid-transfer
    bus_if.bus_en = 1'b0;
    bus_if.req0_valid = 1'b1; bus_if.req0_rs = 1'b1; bus_if.req0_byte = 8'h44;
    saw = 1'b0;
    repeat (10) begin tick(1); saw |= bus_if.req0_ready | bus_if.req1_ready; end
    check_val("d_no_ready", 32'(saw), 0);
    check_val("d_flags", 32'(bus_if.lcd_flags), 0);
    check_val("d_data", 32'(bus_if.lcd_data), 0);
    check_val("d_busy", 32'(bus_if.busy), 0);
    bus_if.bus_en = 1'b1;
    tick(1);
    check_val("d_grant", 32'(bus_if.req0_ready), 1);
    bus_if.req0_valid = 1'b0;
    tick(5);
    bus_if.bus_en = 1'b0;
    bus_if.req1_valid = 1'b1; bus_if.req1_rs = 1'b0; bus_if.req1_byte = 8'h0C;
    wait_idle(PER + 5);
    check_val("d_byte_done", 32'(exp_q.size()), 0);
    saw = 1'b0;
    repeat (20) begin tick(1); saw |= bus_if.req0_ready | bus_if.req1_ready; end
    check_val("d_stall_ready", 32'(saw), 0);
    check_val("d_stall_busy", 32'(bus_if.busy), 0);
    bus_if.bus_en = 1'b1;
    tick(1);
    check_val("d_resume", 32'({bus_if.req1_ready, bus_if.req0_ready}), 'b10);
    bus_if.req1_valid = 1'b0;
    wait_idle(PER + 5);

    // reset while E is high on the upper nibble
    bus_if.req0_valid = 1'b1; bus_if.req0_rs = 1'b1; bus_if.req0_byte = 8'h77;
    tick(1);
    check_val("e_grant", 32'(bus_if.req0_ready), 1);
    bus_if.req0_valid = 1'b0;
    tick(TS);
    check_val("e_pulse", 32'(bus_if.lcd_flags), 'b11);
    rst = 1'b1;
    tick(1);
    check_val("e_rst_flags", 32'(bus_if.lcd_flags), 0);
    check_val("e_rst_data", 32'(bus_if.lcd_data), 0);
    check_val("e_rst_busy", 32'(bus_if.busy), 0);
    rst = 1'b0;
    exp_q.delete();
    tick(10);
    check_val("e_no_restart", 32'(bus_if.busy), 0);
    bus_if.req0_valid = 1'b1; bus_if.req0_byte = 8'h78;
    tick(1);
    check_val("e_fresh", 32'(bus_if.req0_ready), 1);
    bus_if.req0_valid = 1'b0;
    wait_idle(PER + 5);

    // random traffic, including occasional withdrawal before ready
    n_acc = 0;
    n_dec = 0;
    repeat (1500) begin
      tick(1);
      if (bus_if.req0_ready) bus_if.req0_valid = 1'b0;
      else if (!bus_if.req0_valid && $urandom_range(0, 7) == 0) begin
        bus_if.req0_rs    = 1'($urandom_range(0, 1));
        bus_if.req0_byte  = 8'($urandom_range(0, 255));
        bus_if.req0_valid = 1'b1;
      end else if (bus_if.req0_valid && $urandom_range(0, 63) == 0) bus_if.req0_valid = 1'b0;
      if (bus_if.req1_ready) bus_if.req1_valid = 1'b0;
      else if (!bus_if.req1_valid && $urandom_range(0, 7) == 0) begin
        bus_if.req1_rs    = 1'($urandom_range(0, 1));
        bus_if.req1_byte  = 8'($urandom_range(0, 255));
        bus_if.req1_valid = 1'b1;
      end else if (bus_if.req1_valid && $urandom_range(0, 63) == 0) bus_if.req1_valid = 1'b0;
    end
    bus_if.req0_valid = 1'b0;
    bus_if.req1_valid = 1'b0;
    wait_idle(PER_LONG + 5);
    tick(2);
    check_val("f_sb_empty", 32'(exp_q.size()), 0);
    check_val("f_count", 32'(n_dec), 32'(n_acc));
    check_val("f_activity", 32'(n_acc > 5), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
